// File: rtl/pg_recombine_if.sv
// pg_recombine_if: handshake and data bundle between a p/g source and pg_recombine.
//   in_valid/in_ready + p_in/g_in/acc_lvl   : request channel (master -> slave)
//   out_valid/out_ready + sum_out/iters/exact : result channel (slave -> master)
interface pg_recombine_if #(
    parameter int W   = 16,
    parameter int ITW = 5
);
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   p_in;
    logic [W-1:0]   g_in;
    logic [ITW-1:0] acc_lvl;
    logic           out_valid;
    logic           out_ready;
    logic [W+1:0]   sum_out;
    logic [ITW-1:0] iters;
    logic           exact;

    modport master (
        output in_valid, p_in, g_in, acc_lvl, out_ready,
        input  in_ready, out_valid, sum_out, iters, exact
    );

    modport slave (
        input  in_valid, p_in, g_in, acc_lvl, out_ready,
        output in_ready, out_valid, sum_out, iters, exact
    );
endinterface

// File: rtl/pg_recombine.sv
// pg_recombine: iterative p/g recombiner computing p_in + 2*g_in with an optional iteration cap.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pg_recombine_if slave (request in, result out, valid/ready on both sides)
module pg_recombine #(
    parameter int W   = 16,
    parameter int ITW = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    pg_recombine_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state_q, state_d;
    logic [W+1:0]   p_q, p_d, g_q, g_d, sum_q, sum_d;
    logic [ITW-1:0] lim_q, lim_d, cnt_q, cnt_d, iters_q, iters_d;
    logic           exact_q, exact_d;
    logic [W+1:0]   g_sh;
    logic           term;

    assign g_sh = g_q << 1;
    assign term = (g_q == '0) || (lim_q != '0 && cnt_q == lim_q);

    assign bus.in_ready  = state_q == IDLE;
    assign bus.out_valid = state_q == DONE;
    assign bus.sum_out   = sum_q;
    assign bus.iters     = iters_q;
    assign bus.exact     = exact_q;

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        g_d     = g_q;
        lim_d   = lim_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        iters_d = iters_q;
        exact_d = exact_q;
        unique case (state_q)
            IDLE: if (bus.in_valid) begin
                p_d     = {2'b00, bus.p_in};
                g_d     = {2'b00, bus.g_in};
                lim_d   = bus.acc_lvl;
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: if (term) begin
                // Leftover carries are ORed in rather than added when the cap stops us early.
                sum_d   = p_q | g_sh;
                iters_d = cnt_q;
                exact_d = g_q == '0;
                state_d = DONE;
            end else begin
                p_d   = p_q ^ g_sh;
                g_d   = p_q & g_sh;
                cnt_d = cnt_q + 1'b1;
            end
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            p_q     <= '0;
            g_q     <= '0;
            lim_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            iters_q <= '0;
            exact_q <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            g_q     <= g_d;
            lim_q   <= lim_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            iters_q <= iters_d;
            exact_q <= exact_d;
        end
    end
endmodule

// File: tb/tb_pg_recombine.sv
// tb_pg_recombine: randomized self-checking bench for pg_recombine against a behavioural model.
module tb_pg_recombine;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int total = 0;
    int bad = 0;

    pg_recombine_if #(.W(16), .ITW(5)) bus ();
    pg_recombine #(.W(16), .ITW(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // Carry-save style recombination on plain integers: keep adding the shifted carry term
    // until no carries remain or the iteration cap is hit; then OR leftovers in.
    function automatic void model(input logic [15:0] p, input logic [15:0] g, input logic [4:0] lim,
                                  output logic [17:0] s, output logic [4:0] n, output logic e);
        int unsigned pp, cc, t;
        int c;
        pp = p;
        cc = g;
        c = 0;
        while (cc != 0 && !(lim != 0 && c == int'(lim))) begin
            t = (cc * 2) % (1 << 18);
            cc = pp & t;
            pp = pp ^ t;
            c++;
        end
        s = 18'(pp | ((cc * 2) % (1 << 18)));
        n = 5'(c);
        e = cc == 0;
    endfunction

    task automatic run_op(input logic [15:0] p, input logic [15:0] g, input logic [4:0] lvl,
                          input int hold, input string nm);
        logic [17:0] es;
        logic [4:0] en;
        logic ee;
        int k;
        model(p, g, lvl, es, en, ee);
        @(negedge clk);
        bus.p_in = p;
        bus.g_in = g;
        bus.acc_lvl = lvl;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s in_ready_idle got %0b want 1", nm, bus.in_ready);
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        k = 1;
        while (bus.out_valid !== 1'b1 && k < 40) begin
            total++;
            if (bus.in_ready !== 1'b0) begin
                bad++;
                $display("FAIL %s in_ready_run got %0b want 0", nm, bus.in_ready);
            end
            @(posedge clk);
            #1 k++;
        end
        k--;
        total++;
        if (k != int'(en) + 1) begin
            bad++;
            $display("FAIL %s latency got %0d want %0d", nm, k + 1, int'(en) + 2);
        end
        total++;
        if (bus.sum_out !== es || bus.iters !== en || bus.exact !== ee) begin
            bad++;
            $display("FAIL %s result got sum=%h it=%0d ex=%0b want sum=%h it=%0d ex=%0b",
                     nm, bus.sum_out, bus.iters, bus.exact, es, en, ee);
        end
        if (ee) begin
            total++;
            if (bus.sum_out !== 18'(p + 2 * 18'(g))) begin
                bad++;
                $display("FAIL %s exact_sum got %h want %h", nm, bus.sum_out, 18'(p + 2 * 18'(g)));
            end
        end
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            bus.p_in = 16'($urandom);
            bus.g_in = 16'($urandom);
            bus.acc_lvl = 5'($urandom);
            @(posedge clk);
            #1 total++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.sum_out !== es ||
                bus.iters !== en || bus.exact !== ee) begin
                bad++;
                $display("FAIL %s hold%0d got v=%0b r=%0b sum=%h it=%0d ex=%0b want v=1 r=0 sum=%h it=%0d ex=%0b",
                         nm, i, bus.out_valid, bus.in_ready, bus.sum_out, bus.iters, bus.exact, es, en, ee);
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s handshake got v=%0b r=%0b want v=0 r=1", nm, bus.out_valid, bus.in_ready);
        end
        @(posedge clk);
        #1 total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s idle_after got v=%0b r=%0b want v=0 r=1", nm, bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1 total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.sum_out !== '0 ||
            bus.iters !== '0 || bus.exact !== 1'b0) begin
            bad++;
            $display("FAIL reset got v=%0b r=%0b sum=%h it=%0d ex=%0b want v=0 r=1 sum=0 it=0 ex=0",
                     bus.out_valid, bus.in_ready, bus.sum_out, bus.iters, bus.exact);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        run_op(16'h1234, 16'h0000, 5'd0, 0, "no_carry");
        run_op(16'h00FF, 16'h0001, 5'd0, 0, "ripple8");
        run_op(16'h00FF, 16'h0001, 5'd3, 0, "capped3");
        run_op(16'hFFFF, 16'hFFFF, 5'd0, 0, "all_ones");
        run_op(16'hFFFF, 16'h0001, 5'd0, 0, "max_ripple");
        run_op(16'hFFFF, 16'h0001, 5'd16, 0, "cap_at_last");
    endtask

    task automatic test_backpressure();
        run_op(16'h00FF, 16'h0001, 5'd0, 5, "backpressure");
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        bus.p_in = 16'h00FF;
        bus.g_in = 16'h0001;
        bus.acc_lvl = 5'd0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset got v=%0b r=%0b want v=0 r=1", bus.out_valid, bus.in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(posedge clk);
            #1 total++;
            if (bus.out_valid !== 1'b0) begin
                bad++;
                $display("FAIL stale_out got v=%0b want 0", bus.out_valid);
            end
        end
        run_op(16'h00FF, 16'h0001, 5'd0, 0, "after_reset");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [15:0] p, g;
            logic [4:0] l;
            p = 16'($urandom);
            g = ($urandom_range(0, 3) == 0) ? 16'(1 << $urandom_range(0, 15)) : 16'($urandom);
            l = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(1, 6));
            run_op(p, g, l, $urandom_range(0, 3), "random");
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.p_in = '0;
        bus.g_in = '0;
        bus.acc_lvl = '0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pg_recombine.md
# pg_recombine

Multi-cycle recombiner that converts a propagate/generate vector pair back into a binary sum. It computes `sum = p_in + 2*g_in` by iterating `P' = P ^ (G<<1)` and `G' = P & (G<<1)` until carries die out or an accuracy limit is reached. It sits after the per-bit p/g generation stage of the approximate multiplier. The accuracy limit trades result exactness for latency.

## Interface

Parameters:
- `W`, default 16: width of the p/g input vectors.
- `ITW`, default 5: width of the iteration counter and accuracy field. Must satisfy 2^ITW > W+1.

Ports (clock and reset first):
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: input pair is valid.
- `in_ready` output 1: block accepts input; high only in IDLE.
- `p_in` input W: propagate vector.
- `g_in` input W: generate vector, weighted one bit position above `p_in`.
- `acc_lvl` input ITW: maximum iterations. 0 means run to exact completion.
- `out_valid` output 1: result is valid.
- `out_ready` input 1: downstream accepts the result.
- `sum_out` output W+2: result.
- `iters` output ITW: number of iterations performed.
- `exact` output 1: set when G was all-zero at termination.

## Operation

- The internal registers `P_r`, `G_r` are W+2 bits wide; inputs are zero-extended. Shifts truncate to W+2 bits. The true sum never exceeds 3·2^W−3, so nothing is lost.
- The accuracy limit `lim_r` latches `acc_lvl` at accept and is held for the whole operation.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: load `P_r`=`p_in`, `G_r`=`g_in`, `lim_r`=`acc_lvl`, `cnt`=0, then go to RUN.
- RUN: evaluated once per cycle on the current registers.
  - Terminate if `G_r`==0, or if `lim_r`!=0 and `cnt`==`lim_r`.
  - On terminate: latch `sum_out` = `P_r` | (`G_r`<<1), `iters`=`cnt`, `exact`=(`G_r`==0). Go to DONE.
  - Otherwise: perform one iteration and increment `cnt`.
- Exact mode (`lim_r`=0) always terminates within W+1 iterations.
- DONE:
  - `out_valid`=1; `sum_out`, `iters`, `exact` are held stable.
  - On `out_ready`: go to IDLE.
- `in_ready` is 0 in RUN and DONE. `in_valid` outside IDLE is ignored and not queued.
- When `exact`=1, `sum_out` equals `p_in` + 2·`g_in`.
- When `exact`=0, `sum_out` is the OR-approximation: remaining carries are ORed in, not added.

## Timing

- Reset (asynchronous, effective immediately, in any state):
  - State goes to IDLE.
  - `out_valid`=0, `sum_out`=0, `iters`=0, `exact`=0, and internal registers are cleared.
  - `in_ready`=1 from reset onward.
- Reset mid-RUN or mid-DONE discards the operation. No result is ever emitted for it.
- Latency for an accept at edge E0 with n iterations:
  - Iterations occur on edges E1..En.
  - Termination is detected at edge E(n+1).
  - `out_valid` is high from after E(n+1), i.e. latency n+2 cycles.
- When `out_ready` is already high as `out_valid` rises:
  - The handshake completes on the next edge.
  - `in_ready` returns high one cycle after that.
  - Minimum accept-to-accept interval is n+3 cycles.
- Outputs must not change while `out_valid`=1 and `out_ready`=0.
- `in_ready` and `out_valid` are decoded directly from the state register, with no combinational path from the inputs.

## Test plan

- `p_in`=0x1234, `g_in`=0, `acc_lvl`=0 -> `sum_out`=0x01234, `iters`=0, `exact`=1, `out_valid` 2 cycles after accept.
- `p_in`=0x00FF, `g_in`=0x0001, `acc_lvl`=0 -> `sum_out`=0x00101, `iters`=8, `exact`=1, latency 10 cycles.
- `p_in`=0x00FF, `g_in`=0x0001, `acc_lvl`=3 -> `sum_out`=0x000F1, `iters`=3, `exact`=0, latency 5 cycles.
- `p_in`=0xFFFF, `g_in`=0xFFFF, `acc_lvl`=0 -> `sum_out`=0x2FFFD, `iters`=3, `exact`=1.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE and pulse `in_valid` with new data -> outputs stay constant, `in_ready`=0, the new data is ignored; result is accepted once `out_ready`=1.
- Reset: drop `rst_n` during RUN of the 0x00FF/0x0001 case -> `out_valid`=0 and `in_ready`=1 immediately; after release, a new operation completes correctly with no stale output.
